tinyqv_mem_arbiter: RTL



---
 rtl/tinyqv_mem_arbiter_if.sv | 38 +++
 rtl/tinyqv_mem_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tinyqv_mem_arbiter_if.sv
// tinyqv_mem_arbiter_if: CPU-side and QSPI-engine-side bus of the memory arbiter; slave = arbiter, master = CPU plus engine
interface tinyqv_mem_arbiter_if;
  logic [22:0] instr_addr;
  logic        instr_fetch_restart;
  logic        instr_fetch_stall;
  logic        instr_fetch_started;
  logic        instr_fetch_stopped;
  logic [15:0] instr_data;
  logic        instr_ready;
  logic [24:0] data_addr;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic        data_continue;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        spi_start;
  logic [24:0] spi_addr;
  logic        spi_write;
  logic        spi_stop;
  logic        spi_busy;
  logic        spi_rvalid;
  logic [7:0]  spi_rbyte;
  logic        spi_wreq;
  logic [7:0]  spi_wbyte;
  modport slave (
    input  instr_addr, instr_fetch_restart, instr_fetch_stall, data_addr, data_write_n, data_read_n,
           data_continue, data_wdata, spi_busy, spi_rvalid, spi_rbyte, spi_wreq,
    output instr_fetch_started, instr_fetch_stopped, instr_data, instr_ready, data_ready, data_rdata,
           spi_start, spi_addr, spi_write, spi_stop, spi_wbyte
  );
  modport master (
    output instr_addr, instr_fetch_restart, instr_fetch_stall, data_addr, data_write_n, data_read_n,
           data_continue, data_wdata, spi_busy, spi_rvalid, spi_rbyte, spi_wreq,
    input  instr_fetch_started, instr_fetch_stopped, instr_data, instr_ready, data_ready, data_rdata,
           spi_start, spi_addr, spi_write, spi_stop, spi_wbyte
  );
endinterface

// File: rtl/tinyqv_mem_arbiter.sv
// tinyqv_mem_arbiter: serialises CPU fetch/load/store onto a byte engine; ports clk, rstn (async low), bus (slave modport)
module tinyqv_mem_arbiter (
  input logic                  clk,
  input logic                  rstn,
  tinyqv_mem_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, INSTR, DREAD, DWRITE, STOPPING, DWAIT} state_t;
  state_t      state_q;
  logic [1:0]  cnt_q, sz_q;
  logic        odd_q, rel_q;
  logic [24:0] cur_q;
  logic [31:0] wd_q, buf_q;
  logic        started_q, stopped_q, iready_q, dready_q, start_q, write_q, stop_q;
  logic [15:0] idata_q;
  logic [31:0] rdata_q;
  logic [24:0] addr_q;
  logic [7:0]  wbyte_q;
  logic        wr_req, rd_req, dreq, is_last, seq_ok;
  logic [1:0]  last_idx, cnt_nx, req_sz;
  logic [31:0] asm_d, wsh_d;
  logic [24:0] end_d;
  always_comb begin
    wr_req   = bus.data_write_n != 2'b11;
    rd_req   = bus.data_read_n != 2'b11;
    dreq     = wr_req | rd_req;
    req_sz   = wr_req ? bus.data_write_n : bus.data_read_n;
    last_idx = {sz_q[1], |sz_q};
    is_last  = cnt_q == last_idx;
    cnt_nx   = cnt_q + 2'd1;
    asm_d    = buf_q | ({24'b0, bus.spi_rbyte} << {cnt_q, 3'b000});
    wsh_d    = wd_q >> {cnt_nx, 3'b000};
    end_d    = cur_q + {23'b0, last_idx} + 25'd1;
    seq_ok   = bus.data_addr == cur_q && (wr_req == write_q);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sz_q <= '0;
      odd_q <= 1'b0;
      rel_q <= 1'b0;
      cur_q <= '0;
      wd_q <= '0;
      buf_q <= '0;
      started_q <= 1'b0;
      stopped_q <= 1'b0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      start_q <= 1'b0;
      write_q <= 1'b0;
      stop_q <= 1'b0;
      idata_q <= '0;
      rdata_q <= '0;
      addr_q <= '0;
      wbyte_q <= '0;
    end else begin
      started_q <= 1'b0;
      stopped_q <= 1'b0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      case (state_q)
        IDLE: if (!bus.spi_busy && (dreq || bus.instr_fetch_restart)) begin
          start_q <= 1'b1;
          cnt_q <= '0;
          buf_q <= '0;
          if (dreq) begin
            addr_q <= bus.data_addr;
            cur_q <= bus.data_addr;
            write_q <= wr_req;
            sz_q <= req_sz;
            wd_q <= bus.data_wdata;
            wbyte_q <= bus.data_wdata[7:0];
            state_q <= wr_req ? DWRITE : DREAD;
          end else begin
            addr_q <= {bus.instr_addr, 1'b0};
            write_q <= 1'b0;
            odd_q <= 1'b0;
            started_q <= 1'b1;
            state_q <= INSTR;
          end
        end
        // Stop decisions only on the odd byte so a halfword is never split.
        INSTR: if (bus.spi_rvalid) begin
          odd_q <= !odd_q;
          if (!odd_q) idata_q[7:0] <= bus.spi_rbyte;
          else begin
            idata_q[15:8] <= bus.spi_rbyte;
            iready_q <= 1'b1;
            if (bus.instr_fetch_stall || dreq) begin
              stop_q <= 1'b1;
              stopped_q <= 1'b1;
              state_q <= STOPPING;
            end
          end
        end
        DREAD: if (bus.spi_rvalid) begin
          buf_q <= asm_d;
          cnt_q <= cnt_nx;
          if (is_last) begin
            rdata_q <= asm_d;
            dready_q <= 1'b1;
            cur_q <= end_d;
            rel_q <= 1'b0;
            state_q <= DWAIT;
          end
        end
        DWRITE: if (bus.spi_wreq) begin
          cnt_q <= cnt_nx;
          wbyte_q <= wsh_d[7:0];
          if (is_last) begin
            dready_q <= 1'b1;
            cur_q <= end_d;
            rel_q <= 1'b0;
            state_q <= DWAIT;
          end
        end
        // rel_q marks that the completed request has been withdrawn, so any request seen afterwards is a new one.
        DWAIT: begin
          if (!dreq && bus.data_continue) rel_q <= 1'b1;
          if (rel_q && dreq && seq_ok) begin
            cnt_q <= '0;
            buf_q <= '0;
            sz_q <= req_sz;
            wd_q <= bus.data_wdata;
            wbyte_q <= bus.data_wdata[7:0];
            state_q <= wr_req ? DWRITE : DREAD;
          end else if ((!dreq && !bus.data_continue) || (rel_q && dreq)) begin
            stop_q <= 1'b1;
            state_q <= STOPPING;
          end
        end
        STOPPING: if (!bus.spi_busy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.instr_fetch_started = started_q;
  assign bus.instr_fetch_stopped = stopped_q;
  assign bus.instr_data          = idata_q;
  assign bus.instr_ready         = iready_q;
  assign bus.data_ready          = dready_q;
  assign bus.data_rdata          = rdata_q;
  assign bus.spi_start           = start_q;
  assign bus.spi_addr            = addr_q;
  assign bus.spi_write           = write_q;
  assign bus.spi_stop            = stop_q;
  assign bus.spi_wbyte           = wbyte_q;
endmodule
